bfifo_pos_gen: RTL and testbench



---
 rtl/bfifo_pos_gen.sv | 129 ++++++++++++
 tb/tb_bfifo_pos_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bfifo_pos_gen.sv
// Raster coordinate generator feeding the boundary fake-pblk calculator.
// Optional BFIFO_POSGEN_BOUNDARY_ONLY_EN: emit only the right-column / bottom-row positions.
module bfifo_pos_gen #(
    parameter int UNIT = 4,
    parameter int CW   = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] pic_width_in_luma_samples,
    input  logic [CW-1:0] pic_height_in_luma_samples,
    output logic [CW-1:0] x1,
    output logic [CW-1:0] y1,
    output logic          pos_valid,
    input  logic          pos_ready,
    output logic          pos_last,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] W_UNIT = CW'(UNIT);
    localparam logic [CW-1:0] W_MASK = CW'(UNIT - 1);

    // Handshake: a position moves when pos_valid && pos_ready at a rising edge;
    // pos_valid is never withdrawn and x1/y1 are frozen until that transfer.

    logic [1:0]    r_state;
    logic [CW-1:0] r_w;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_valid;
    logic          r_err;

    logic w_xfer;
    logic w_at_end;
    logic w_bad_dims;

    assign w_xfer     = r_valid && pos_ready;
    assign w_at_end   = (r_x == r_w) && (r_y == r_h);
    assign w_bad_dims = (pic_width_in_luma_samples == '0) ||
                        (pic_height_in_luma_samples == '0) ||
                        ((pic_width_in_luma_samples & W_MASK) != '0) ||
                        ((pic_height_in_luma_samples & W_MASK) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_w     <= '0;
            r_h     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_bad_dims) begin
                            r_err <= 1'b1;
                        end else begin
                            r_w     <= pic_width_in_luma_samples;
                            r_h     <= pic_height_in_luma_samples;
`ifdef BFIFO_POSGEN_BOUNDARY_ONLY_EN
                            r_x     <= pic_width_in_luma_samples;
`else
                            r_x     <= '0;
`endif
                            r_y     <= '0;
                            r_valid <= 1'b1;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_xfer) begin
                        if (w_at_end) begin
                            r_valid <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
`ifdef BFIFO_POSGEN_BOUNDARY_ONLY_EN
                            // Walk down the right column, then sweep the bottom row from x=0.
                            if (r_y < r_h) begin
                                if ((r_y + W_UNIT) == r_h) begin
                                    r_x <= '0;
                                end
                                r_y <= r_y + W_UNIT;
                            end else begin
                                r_x <= r_x + W_UNIT;
                            end
`else
                            if (r_x < r_w) begin
                                r_x <= r_x + W_UNIT;
                            end else begin
                                r_x <= '0;
                                r_y <= r_y + W_UNIT;
                            end
`endif
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign x1        = r_x;
    assign y1        = r_y;
    assign pos_valid = r_valid;
    assign pos_last  = r_valid && w_at_end;
    assign busy      = (r_state == S_SCAN);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bfifo_pos_gen.sv
// Directed bench for bfifo_pos_gen: table of picture scans plus error, reset and restart sequences.
module tb_bfifo_pos_gen;

    localparam int UNIT = 4;
    localparam int CW   = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] pic_w = '0;
    logic [CW-1:0] pic_h = '0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic          pos_valid;
    logic          pos_ready = 1'b0;
    logic          pos_last;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*CW-1:0] exp_q[$];

    bfifo_pos_gen #(.UNIT(UNIT), .CW(CW)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .start                      (start),
        .pic_width_in_luma_samples  (pic_w),
        .pic_height_in_luma_samples (pic_h),
        .x1                         (x1),
        .y1                         (y1),
        .pos_valid                  (pos_valid),
        .pos_ready                  (pos_ready),
        .pos_last                   (pos_last),
        .busy                       (busy),
        .done                       (done),
        .err                        (err),
        .dbg_state                  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected position order for one picture.
    task automatic build_expected(input int w, input int h);
        exp_q.delete();
`ifdef BFIFO_POSGEN_BOUNDARY_ONLY_EN
        for (int y = 0; y < h; y += UNIT) exp_q.push_back({CW'(w), CW'(y)});
        for (int x = 0; x <= w; x += UNIT) exp_q.push_back({CW'(x), CW'(h)});
`else
        for (int y = 0; y <= h; y += UNIT)
            for (int x = 0; x <= w; x += UNIT) exp_q.push_back({CW'(x), CW'(y)});
`endif
    endtask

    // Runs one scan, checking every presented position; restart_at >= 0 pulses a second start mid-scan.
    task automatic run_scan(input int w, input int h, input bit stall, input int exp_n, input int restart_at);
        int n_xfer = 0;
        int iter = 0;
        bit fin = 1'b0;
        build_expected(w, h);
        @(negedge clk);
        start = 1'b1; pic_w = CW'(w); pic_h = CW'(h); pos_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_valid", {31'd0, pos_valid}, 32'd1);
        chk("busy_on", {31'd0, busy}, 32'd1);
        chk("no_err", {31'd0, err}, 32'd0);
        while (!fin && iter < 20000) begin
            start = 1'b0;
            if (iter == restart_at) begin
                start = 1'b1; pic_w = CW'(32); pic_h = CW'(32);
            end
            if (exp_q.size() == 0) begin
                chk("valid_drop", {31'd0, pos_valid}, 32'd0);
                chk("done_pulse", {31'd0, done}, 32'd1);
                chk("busy_off", {31'd0, busy}, 32'd0);
                fin = 1'b1;
            end else begin
                chk("valid", {31'd0, pos_valid}, 32'd1);
                chk("x1", {19'd0, x1}, {19'd0, exp_q[0][2*CW-1:CW]});
                chk("y1", {19'd0, y1}, {19'd0, exp_q[0][CW-1:0]});
                chk("last", {31'd0, pos_last}, {31'd0, exp_q.size() == 1});
                chk("done_low", {31'd0, done}, 32'd0);
                pos_ready = stall ? ~pos_ready : 1'b1;
                if (pos_ready) begin
                    void'(exp_q.pop_front());
                    n_xfer++;
                end
            end
            @(negedge clk);
            iter++;
        end
        start = 1'b0;
        chk("scan_finished", {31'd0, fin}, 32'd1);
        chk("xfer_count", n_xfer, exp_n);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_state", {30'd0, dbg_state}, 32'd0);
    endtask

    typedef struct {
        int w;
        int h;
        bit stall;
        int restart_at;
        int n_full;
        int n_bnd;
    } scan_vec_t;

    typedef struct {
        int w;
        int h;
    } bad_vec_t;

    scan_vec_t scans[6];
    bad_vec_t  bads[4];

    initial begin
        scans[0] = '{w: 16,   h: 8, stall: 1'b0, restart_at: -1, n_full: 15,   n_bnd: 7};
        scans[1] = '{w: 16,   h: 8, stall: 1'b1, restart_at: -1, n_full: 15,   n_bnd: 7};
        scans[2] = '{w: 16,   h: 8, stall: 1'b0, restart_at: 3,  n_full: 15,   n_bnd: 7};
        scans[3] = '{w: 8,    h: 4, stall: 1'b1, restart_at: -1, n_full: 6,    n_bnd: 4};
        scans[4] = '{w: 4,    h: 4, stall: 1'b0, restart_at: -1, n_full: 4,    n_bnd: 3};
        scans[5] = '{w: 8188, h: 4, stall: 1'b0, restart_at: -1, n_full: 4096, n_bnd: 2049};
        bads[0]  = '{w: 18, h: 8};
        bads[1]  = '{w: 0,  h: 8};
        bads[2]  = '{w: 16, h: 0};
        bads[3]  = '{w: 16, h: 6};

        // Reset values
        @(negedge clk);
        chk("rst_valid", {31'd0, pos_valid}, 32'd0);
        chk("rst_x1", {19'd0, x1}, 32'd0);
        chk("rst_y1", {19'd0, y1}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_last", {31'd0, pos_last}, 32'd0);
        rst = 1'b0;

        // Illegal dimensions
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b1; pic_w = CW'(bads[i].w); pic_h = CW'(bads[i].h);
            @(negedge clk);
            start = 1'b0;
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_no_valid", {31'd0, pos_valid}, 32'd0);
            chk("err_no_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("err_one_cycle", {31'd0, err}, 32'd0);
        end

        // Scan table
        for (int i = 0; i < 6; i++) begin
`ifdef BFIFO_POSGEN_BOUNDARY_ONLY_EN
            run_scan(scans[i].w, scans[i].h, scans[i].stall, scans[i].n_bnd, scans[i].restart_at);
`else
            run_scan(scans[i].w, scans[i].h, scans[i].stall, scans[i].n_full, scans[i].restart_at);
`endif
        end

        // Reset in the middle of a scan, after six transfers
        @(negedge clk);
        start = 1'b1; pic_w = CW'(16); pic_h = CW'(8); pos_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_valid", {31'd0, pos_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, pos_valid}, 32'd0);
        chk("mid_rst_x1", {19'd0, x1}, 32'd0);
        chk("mid_rst_y1", {19'd0, y1}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_last", {31'd0, pos_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("post_rst_no_done", {31'd0, done}, 32'd0);
`ifdef BFIFO_POSGEN_BOUNDARY_ONLY_EN
        run_scan(8, 4, 1'b0, 4, -1);
`else
        run_scan(8, 4, 1'b0, 6, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
